// File: rtl/fifo_mem_array.sv
// fifo_mem_array: storage for sized_fifo_sync.
//   Synchronous write port (we, waddr, wdata) on posedge CLK.
//   Asynchronous read port (raddr -> rdata).
//   No reset: contents are left undefined so the array can map onto
//   FPGA distributed RAM or LUT storage.
// Ports:
//   CLK   in  1                      clock
//   we    in  1                      write enable
//   waddr in  $clog2(depth)          write address
//   wdata in  width                  write data
//   raddr in  $clog2(depth)          read address
//   rdata out width                  read data (combinational)
module fifo_mem_array #(
  parameter int width = 1,
  parameter int depth = 2
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0]         wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sized_fifo_sync.sv
// sized_fifo_sync: parameterised-depth single-clock FIFO with
// Bluespec-style ENQ/FULL_N and DEQ/EMPTY_N handshakes.
// Only control state is reset; storage lives in fifo_mem_array and is not.
// Ports:
//   CLK     in  1      clock, all updates on posedge
//   RST     in  1      synchronous active-high reset (highest priority)
//   D_IN    in  width  enqueue data
//   ENQ     in  1      enqueue request
//   FULL_N  out 1      registered: at least one entry free
//   DEQ     in  1      dequeue request
//   EMPTY_N out 1      registered: at least one entry valid
//   D_OUT   out width  head entry, valid while EMPTY_N=1
//   CLR     in  1      synchronous flush (ERR preserved)
//   COUNT   out cntw   registered number of valid entries
//   ERR     out 1      sticky flag: illegal ENQ or DEQ seen
module sized_fifo_sync #(
  parameter int width   = 1,
  parameter int depth   = 2,
  parameter int cntw    = 2,
  parameter int guarded = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] D_IN,
  input  logic             ENQ,
  output logic             FULL_N,
  input  logic             DEQ,
  output logic             EMPTY_N,
  output logic [width-1:0] D_OUT,
  input  logic             CLR,
  output logic [cntw-1:0]  COUNT,
  output logic             ERR
);

  localparam int AW = $clog2(depth);
  localparam logic [cntw-1:0] DEPTH_C = cntw'(depth);
  localparam logic [AW-1:0]   LAST_C  = AW'(depth - 1);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [cntw-1:0] count_r;
  logic            full_n_r;
  logic            empty_n_r;
  logic            err_r;

  logic            enq_ok;
  logic            deq_ok;
  logic            enq_bad;
  logic            deq_bad;
  logic            mem_we;
  logic [cntw-1:0] count_nxt;

  // Pointers wrap explicitly so depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Legality is judged against the registered flags, so a full FIFO never
  // accepts a write even when a DEQ frees a slot in the same cycle.
  assign enq_ok  = ENQ & full_n_r;
  assign deq_ok  = DEQ & empty_n_r;
  assign enq_bad = ENQ & ~full_n_r;
  assign deq_bad = DEQ & ~empty_n_r;
  assign mem_we  = enq_ok & ~CLR & ~RST;

  always_comb begin
    count_nxt = count_r;
    case ({enq_ok, deq_ok})
      2'b10:   count_nxt = count_r + 1'b1;
      2'b01:   count_nxt = count_r - 1'b1;
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      full_n_r  <= 1'b1;
      empty_n_r <= 1'b0;
      err_r     <= 1'b0;
    end else if (CLR) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      full_n_r  <= 1'b1;
      empty_n_r <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (deq_ok) rd_ptr <= ptr_inc(rd_ptr);
      count_r   <= count_nxt;
      full_n_r  <= (count_nxt != DEPTH_C);
      empty_n_r <= (count_nxt != '0);
      err_r     <= err_r | enq_bad | deq_bad;
    end
  end

  // Simulation-only warnings for protocol violations.
  generate
    if (guarded != 0) begin : g_guard
      always @(posedge CLK) begin
        if (!RST && !CLR) begin
          if (enq_bad) $display("Warning: %m: ENQ while full ignored");
          if (deq_bad) $display("Warning: %m: DEQ while empty ignored");
        end
      end
    end
  endgenerate

  fifo_mem_array #(
    .width(width),
    .depth(depth)
  ) u_mem (
    .CLK  (CLK),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(D_IN),
    .raddr(rd_ptr),
    .rdata(D_OUT)
  );

  assign FULL_N  = full_n_r;
  assign EMPTY_N = empty_n_r;
  assign COUNT   = count_r;
  assign ERR     = err_r;

endmodule

// File: tb/tb_sized_fifo_sync.sv
// Directed testbench for sized_fifo_sync (width=8, depth=3, cntw=2).
// Inputs change 1 time unit after posedge; outputs are checked there too.
module tb_sized_fifo_sync;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] D_IN = '0;
  logic       ENQ = 1'b0;
  logic       DEQ = 1'b0;
  logic       CLR = 1'b0;
  logic       FULL_N;
  logic       EMPTY_N;
  logic [7:0] D_OUT;
  logic [1:0] COUNT;
  logic       ERR;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  sized_fifo_sync #(
    .width  (8),
    .depth  (3),
    .cntw   (2),
    .guarded(1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .D_IN   (D_IN),
    .ENQ    (ENQ),
    .FULL_N (FULL_N),
    .DEQ    (DEQ),
    .EMPTY_N(EMPTY_N),
    .D_OUT  (D_OUT),
    .CLR    (CLR),
    .COUNT  (COUNT),
    .ERR    (ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs held across the edge, then idle inputs.
  task automatic cyc(input logic rst, input logic clr, input logic enq,
                     input logic deq, input logic [7:0] din);
    RST = rst; CLR = clr; ENQ = enq; DEQ = deq; D_IN = din;
    @(posedge CLK);
    #1;
    RST = 1'b0; CLR = 1'b0; ENQ = 1'b0; DEQ = 1'b0; D_IN = '0;
  endtask

  initial begin
    #1;
    // Reset for two cycles
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    chk("rst_count",   COUNT,   0);
    chk("rst_full_n",  FULL_N,  1);
    chk("rst_empty_n", EMPTY_N, 0);
    chk("rst_err",     ERR,     0);

    // Illegal DEQ on empty, CLR keeps ERR, RST clears it
    cyc(0, 0, 0, 1, 8'h00);
    chk("ill_deq_err",   ERR,   1);
    chk("ill_deq_count", COUNT, 0);
    cyc(0, 1, 0, 0, 8'h00);
    chk("clr_keeps_err", ERR, 1);
    cyc(1, 0, 0, 0, 8'h00);
    chk("rst_clears_err", ERR, 0);

    // Fill and drain
    cyc(0, 0, 1, 0, 8'h11);
    chk("fill1_empty_n", EMPTY_N, 1);
    chk("fill1_dout",    D_OUT,   8'h11);
    chk("fill1_count",   COUNT,   1);
    cyc(0, 0, 1, 0, 8'h22);
    cyc(0, 0, 1, 0, 8'h33);
    chk("fill3_full_n", FULL_N, 0);
    chk("fill3_count",  COUNT,  3);
    chk("drain_d0", D_OUT, 8'h11);
    cyc(0, 0, 0, 1, 8'h00);
    chk("drain_d1", D_OUT, 8'h22);
    chk("drain_full_n", FULL_N, 1);
    cyc(0, 0, 0, 1, 8'h00);
    chk("drain_d2", D_OUT, 8'h33);
    cyc(0, 0, 0, 1, 8'h00);
    chk("drain_empty_n", EMPTY_N, 0);
    chk("drain_count",   COUNT,   0);
    chk("drain_err",     ERR,     0);

    // Wrap-around: enqueue one, dequeue one, ten times
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 8'(i));
      chk($sformatf("wrap_dout_%0d", i),  D_OUT, i);
      chk($sformatf("wrap_cnt1_%0d", i),  COUNT, 1);
      cyc(0, 0, 0, 1, 8'h00);
      chk($sformatf("wrap_cnt0_%0d", i),  COUNT, 0);
    end
    chk("wrap_err", ERR, 0);

    // Simultaneous ENQ+DEQ with COUNT=1
    cyc(0, 0, 1, 0, 8'hAA);
    chk("sim1_head", D_OUT, 8'hAA);
    cyc(0, 0, 1, 1, 8'hBB);
    chk("sim1_count", COUNT, 1);
    chk("sim1_dout",  D_OUT, 8'hBB);
    chk("sim1_err",   ERR,   0);

    // Full FIFO: ENQ+DEQ -> DEQ only, ERR set
    cyc(0, 0, 1, 0, 8'h01);
    cyc(0, 0, 1, 0, 8'h02);
    chk("full_count", COUNT, 3);
    cyc(0, 0, 1, 1, 8'hFF);
    chk("fullsim_count",  COUNT,  2);
    chk("fullsim_err",    ERR,    1);
    chk("fullsim_dout",   D_OUT,  8'h01);
    chk("fullsim_full_n", FULL_N, 1);
    cyc(0, 0, 0, 1, 8'h00);
    chk("fullsim_d1", D_OUT, 8'h02);
    cyc(0, 0, 0, 1, 8'h00);
    chk("fullsim_empty", EMPTY_N, 0);

    // Empty FIFO: ENQ+DEQ -> ENQ only, ERR set
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 1, 8'hCC);
    chk("emptysim_count", COUNT, 1);
    chk("emptysim_dout",  D_OUT, 8'hCC);
    chk("emptysim_err",   ERR,   1);

    // Flush mid-operation, ENQ in the CLR cycle is discarded
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h01);
    cyc(0, 0, 1, 0, 8'h02);
    chk("flush_pre_count", COUNT, 2);
    cyc(0, 1, 1, 0, 8'h77);
    chk("flush_count",   COUNT,   0);
    chk("flush_empty_n", EMPTY_N, 0);
    chk("flush_full_n",  FULL_N,  1);
    cyc(0, 0, 1, 0, 8'h5A);
    chk("postflush_dout",  D_OUT, 8'h5A);
    chk("postflush_count", COUNT, 1);
    chk("postflush_err",   ERR,   0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sized_fifo_sync.md
Name: sized_fifo_sync

Overview:
- Parameterised-depth synchronous FIFO that buffers a data stream ahead of the unreset pipeline registers in the BSV primitive library.
- Provides Bluespec-style ENQ/FULL_N and DEQ/EMPTY_N handshakes on one clock.
- Storage is deliberately not reset, to suit FPGA RAM/LUT inference; only the control state is reset.
- Intended as the buffering stage that feeds downstream held registers in the Xilinx IP wrappers.

Parameters:
- width, 1: data bit width; must be at least 1.
- depth, 2: number of entries; must be at least 2; need not be a power of two.
- cntw, 2: width of COUNT; must satisfy 2^cntw > depth.
- guarded, 1: when 1, simulation prints $display warnings on illegal ENQ or DEQ.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- D_IN  in  width  enqueue data.
- ENQ  in  1  enqueue request.
- FULL_N  out  1  high when at least one entry is free.
- DEQ  in  1  dequeue request.
- EMPTY_N  out  1  high when at least one entry is valid.
- D_OUT  out  width  head entry; valid only while EMPTY_N=1.
- CLR  in  1  synchronous flush.
- COUNT  out  cntw  number of valid entries.
- ERR  out  1  sticky flag for illegal ENQ or DEQ.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high. RST is sampled only at the posedge of CLK.
- Reset values when RST=1 at a posedge: wr_ptr=0, rd_ptr=0, COUNT=0, FULL_N=1, EMPTY_N=0, ERR=0.
- Storage array is not reset. RST has priority over every other input.
- CLR=1 (with RST=0) at a posedge:
  - Pointers and COUNT return to 0; FULL_N=1, EMPTY_N=0.
  - ERR is unchanged.
  - Any ENQ or DEQ in the same cycle is discarded. Storage is not written.
- Legal enqueue: ENQ=1 and FULL_N=1.
  - Write D_IN to mem[wr_ptr].
  - wr_ptr advances: if wr_ptr==depth-1 it becomes 0, otherwise wr_ptr+1.
- Legal dequeue: DEQ=1 and EMPTY_N=1.
  - rd_ptr advances with the same wrap rule.
- Simultaneous legal ENQ and DEQ: both take effect; COUNT is unchanged.
  - If COUNT==1, the new data appears on D_OUT the next cycle.
- Illegal ENQ (ENQ=1, FULL_N=0) is ignored: no write and no pointer move. ERR is set to 1.
- Illegal DEQ (DEQ=1, EMPTY_N=0) is ignored. ERR is set to 1.
- If guarded=1, each illegal ENQ or DEQ prints a warning that includes %m.
- When full, ENQ+DEQ in the same cycle: the DEQ takes effect, the ENQ is illegal and ERR is set. No write-through; the producer must see FULL_N high first.
- When empty, ENQ+DEQ in the same cycle: the ENQ takes effect, the DEQ is illegal and ERR is set. No bypass.
- Latency: data enqueued at edge N is visible on D_OUT and EMPTY_N after edge N, when the FIFO was empty.
- D_OUT is mem[rd_ptr], read combinationally from the registered pointer.
- Output timing: FULL_N, EMPTY_N, COUNT and ERR are registered. They update at the same edge as the pointers.
- Output encoding: FULL_N = (COUNT != depth) and EMPTY_N = (COUNT != 0), maintained as registers.
- COUNT arithmetic: +1 on legal ENQ only, -1 on legal DEQ only, unchanged on both or neither. It never exceeds depth and never underflows.
- Initial blocks: none for control state; simulation relies on RST being asserted.

Decomposition:
- No shared package; all constants are module parameters.
- One natural sub-module, fifo_mem_array (parameters width, depth):
  - Synchronous write port: we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
  - No reset.
- Pointer/count control stays in sized_fifo_sync.

Test Plan:
- Reset: RST=1 for 2 cycles, then 0 -> COUNT=0, FULL_N=1, EMPTY_N=0, ERR=0.
- Fill and drain with depth=3, width=8: enqueue 0x11, 0x22, 0x33 -> FULL_N=0, COUNT=3. Then three DEQs -> D_OUT reads 0x11, 0x22, 0x33 in order, finishing with EMPTY_N=0.
- Wrap-around with depth=3: repeat enqueue-1/dequeue-1 for 10 values 0x00–0x09 -> every value is dequeued in order, COUNT stays ≤1, ERR=0.
- Simultaneous events:
  - COUNT=1 (head 0xAA), ENQ 0xBB + DEQ -> COUNT=1, D_OUT=0xBB next cycle.
  - Full FIFO, ENQ+DEQ -> COUNT=depth-1, ERR=1.
  - Empty FIFO, ENQ 0xCC + DEQ -> COUNT=1, D_OUT=0xCC, ERR=1.
- Illegal access: DEQ on empty after reset -> ERR=1, COUNT=0. Then CLR -> ERR stays 1. Then RST -> ERR=0.
- Flush mid-operation: COUNT=2, then CLR with ENQ=1 in the same cycle -> COUNT=0, EMPTY_N=0. Next ENQ 0x5A -> D_OUT=0x5A, COUNT=1.
